// File: rtl/fp_norm_pkg.sv
// Shared definitions for the significand normalization stage.
// Holds the FSM state encoding, the default datapath widths and the
// width of the shift counter derived from the fraction width.
package fp_norm_pkg;

  localparam int FRAC_W_DEF  = 23;
  localparam int EXP_W_DEF   = 8;
  localparam int SIG_W_DEF   = FRAC_W_DEF + 1;
  localparam int SHIFT_W_DEF = $clog2(FRAC_W_DEF + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } norm_state_e;

  // Width of a counter able to hold 0..frac_w shifts (with headroom).
  function automatic int shift_width(input int frac_w);
    return $clog2(frac_w + 2);
  endfunction

endpackage

// File: rtl/fp_sum_normalizer.sv
// Left-normalizes the mantissa adder result one bit per cycle.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for an operand; in_ready=1
// SHIFT | shifting sig left / decrementing exp until normalized
//       | or the exponent reaches 0 (underflow)
// DONE  | result held on the outputs with out_valid=1
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   in_sum, in_carry      adder sum/carry; significand = {carry, sum}
//   in_exp, in_sign       tentative biased exponent and sign
//   out_valid/out_ready   output handshake
//   out_frac, out_exp     normalized fraction (integer bit dropped), exponent
//   out_sign              registered sign
//   out_zero              significand was zero
//   out_underflow         exponent hit 0 before normalization finished
//   out_shift             number of left shifts applied
module fp_sum_normalizer
  import fp_norm_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FRAC_W-1:0]               in_sum,
  input  logic                            in_carry,
  input  logic [EXP_W-1:0]                in_exp,
  input  logic                            in_sign,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FRAC_W-1:0]               out_frac,
  output logic [EXP_W-1:0]                out_exp,
  output logic                            out_sign,
  output logic                            out_zero,
  output logic                            out_underflow,
  output logic [$clog2(FRAC_W+2)-1:0]     out_shift
);

  localparam int SIG_W   = FRAC_W + 1;
  localparam int SHIFT_W = $clog2(FRAC_W + 2);

  norm_state_e        state_q;
  logic [SIG_W-1:0]   sig_q;
  logic [EXP_W-1:0]   exp_q;
  logic               sign_q;
  logic               zero_q;
  logic               uf_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               valid_q;

  logic [SIG_W-1:0]   sig_in;
  assign sig_in = {in_carry, in_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sig_q   <= sig_in;
            exp_q   <= in_exp;
            sign_q  <= in_sign;
            shift_q <= '0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            if (sig_in == '0) begin
              zero_q  <= 1'b1;
              exp_q   <= '0;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else if (sig_in[FRAC_W]) begin
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (sig_q[FRAC_W]) begin
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (exp_q == '0) begin
            // Denormal: stop shifting and leave the fraction where it is.
            uf_q    <= 1'b1;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            sig_q   <= {sig_q[SIG_W-2:0], 1'b0};
            exp_q   <= exp_q - EXP_W'(1);
            shift_q <= shift_q + SHIFT_W'(1);
          end
        end
        ST_DONE: begin
          // No accept in the same cycle; IDLE takes the next operand.
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = valid_q;
  assign out_frac      = sig_q[FRAC_W-1:0];
  assign out_exp       = exp_q;
  assign out_sign      = sign_q;
  assign out_zero      = zero_q;
  assign out_underflow = uf_q;
  assign out_shift     = shift_q;

endmodule

// File: tb/tb_fp_sum_normalizer.sv
// Directed testbench for fp_sum_normalizer with hand-computed vectors.
module tb_fp_sum_normalizer;

  localparam int FW = 23;
  localparam int EW = 8;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_sum = '0;
  logic          in_carry = 1'b0;
  logic [EW-1:0] in_exp = '0;
  logic          in_sign = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FW-1:0] out_frac;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic          out_zero;
  logic          out_underflow;
  logic [SW-1:0] out_shift;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_sum_normalizer #(.FRAC_W(FW), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_frac(out_frac), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_underflow(out_underflow), .out_shift(out_shift)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_result(input string tag, input logic [FW-1:0] frac, input logic [EW-1:0] e,
                              input logic s, input logic z, input logic uf, input logic [SW-1:0] sh);
    check_eq({tag, ".frac"},  32'(out_frac), 32'(frac));
    check_eq({tag, ".exp"},   32'(out_exp), 32'(e));
    check_eq({tag, ".sign"},  32'(out_sign), 32'(s));
    check_eq({tag, ".zero"},  32'(out_zero), 32'(z));
    check_eq({tag, ".uf"},    32'(out_underflow), 32'(uf));
    check_eq({tag, ".shift"}, 32'(out_shift), 32'(sh));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".ready"}, 32'(in_ready), 32'd1);
    check_result(tag, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Present one operand, wait for the result, check latency and fields.
  task automatic run_op(input string tag, input logic c, input logic [FW-1:0] sm,
                        input logic [EW-1:0] e, input logic s,
                        input logic [FW-1:0] x_frac, input logic [EW-1:0] x_exp,
                        input logic x_sign, input logic x_zero, input logic x_uf,
                        input logic [SW-1:0] x_shift, input int x_lat, input bit ack);
    int lat;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_carry = c; in_sum = sm; in_exp = e; in_sign = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'(x_lat));
    check_eq({tag, ".busy"}, 32'(in_ready), 32'd0);
    check_result(tag, x_frac, x_exp, x_sign, x_zero, x_uf, x_shift);
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: already normalized
    run_op("t1", 1'b1, 23'h000000, 8'h80, 1'b1, 23'h000000, 8'h80, 1'b1, 1'b0, 1'b0, 5'd0, 1, 1'b1);
    // 2: worst case, 23 shifts
    run_op("t2", 1'b0, 23'h000001, 8'h80, 1'b0, 23'h000000, 8'h69, 1'b0, 1'b0, 1'b0, 5'd23, 25, 1'b1);
    // 3: zero significand
    run_op("t3", 1'b0, 23'h000000, 8'h55, 1'b0, 23'h000000, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1, 1'b1);
    // 4: underflow after 2 shifts
    run_op("t4", 1'b0, 23'h100000, 8'h02, 1'b1, 23'h400000, 8'h00, 1'b1, 1'b0, 1'b1, 5'd2, 4, 1'b1);
    // single shift
    run_op("t1s", 1'b0, 23'h400000, 8'h10, 1'b0, 23'h000000, 8'h0F, 1'b0, 1'b0, 1'b0, 5'd1, 3, 1'b1);
    // exponent already 0, unnormalized: immediate underflow, no shift
    run_op("te0", 1'b0, 23'h7FFFFF, 8'h00, 1'b0, 23'h7FFFFF, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 2, 1'b1);

    // 5: backpressure in DONE with a second operand waiting
    run_op("t5a", 1'b1, 23'h000000, 8'h80, 1'b1, 23'h000000, 8'h80, 1'b1, 1'b0, 1'b0, 5'd0, 1, 1'b0);
    in_valid = 1'b1; in_carry = 1'b1; in_sum = 23'h123456; in_exp = 8'h10; in_sign = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t5.hold_valid", 32'(out_valid), 32'd1);
      check_eq("t5.hold_ready", 32'(in_ready), 32'd0);
      check_result("t5.hold", 23'h000000, 8'h80, 1'b1, 1'b0, 1'b0, 5'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("t5.idle_ready", 32'(in_ready), 32'd1);
    check_eq("t5.idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("t5b.valid", 32'(out_valid), 32'd1);
    check_result("t5b", 23'h123456, 8'h10, 1'b0, 1'b0, 1'b0, 5'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // 6: asynchronous reset in the middle of SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_carry = 1'b0; in_sum = 23'h000001; in_exp = 8'h80; in_sign = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("t6.rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t6.after", 1'b1, 23'h000000, 8'h80, 1'b1, 23'h000000, 8'h80, 1'b1, 1'b0, 1'b0, 5'd0, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_sum_normalizer.md
# fp_sum_normalizer

Normalization stage for the single-precision significand datapath. It sits directly downstream of the 23-bit carry-select mantissa adder and consumes that adder's `sum_out`/`carry_out` pair, together with the tentative exponent and sign from the alignment logic. It left-normalizes the 24-bit significand iteratively, one bit per cycle, decrementing the exponent and flagging zero and underflow results. Results are delivered over a valid/ready handshake to the rounding/pack stage.

## Interface
Parameters:
- `FRAC_W`, 23, fraction width; equals the adder width.
- `EXP_W`, 8, exponent width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  stage can accept an input.
- `in_sum`  in  FRAC_W  adder `sum_out`; low bits of the significand.
- `in_carry`  in  1  adder `carry_out`; integer bit of the significand (bit FRAC_W).
- `in_exp`  in  EXP_W  biased exponent before normalization.
- `in_sign`  in  1  result sign; passed through unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_frac`  out  FRAC_W  normalized fraction, with the integer bit dropped.
- `out_exp`  out  EXP_W  adjusted biased exponent.
- `out_sign`  out  1  registered `in_sign`.
- `out_zero`  out  1  significand was all zero.
- `out_underflow`  out  1  exponent reached 0 before normalization completed (denormal result).
- `out_shift`  out  clog2(FRAC_W+2)  number of left shifts applied.

## Operation
- The internal significand is `sig = {in_carry, in_sum}` (FRAC_W+1 bits). It is normalized when `sig[FRAC_W]` is 1.
- FSM states: IDLE, SHIFT, DONE.
- `in_ready` is 1 exactly when the state is IDLE.
- **IDLE, on `in_valid`:** capture `sig`, `exp`, and `sign`, and clear `shift`. Then:
  - If `sig` is 0: go to DONE with zero=1, exp=0, frac=0.
  - Else if `sig[FRAC_W]` is 1: go to DONE.
  - Else: go to SHIFT.
- **SHIFT, evaluated once per cycle in this priority order:**
  1. `sig[FRAC_W]`=1: go to DONE.
  2. `exp`=0: go to DONE with underflow=1; the fraction is left as is.
  3. Otherwise: `sig <<= 1`, `exp -= 1`, `shift += 1`, and stay in SHIFT.
- **DONE:** `out_valid`=1 and all outputs are held stable. On `out_ready` the FSM returns to IDLE.
- There is no same-cycle accept in DONE, so the next input is accepted at the earliest one cycle after the output handshake.
- The exponent never wraps below 0, and `shift` never exceeds FRAC_W.
- Reset (asserted at any time, including mid-SHIFT or in DONE with an unread result):
  - State returns to IDLE; all registers are cleared.
  - `out_valid`=0, `in_ready`=1.
  - `out_frac`, `out_exp`, `out_sign`, `out_zero`, `out_underflow`, and `out_shift` are all 0.
  - Any result in flight is discarded.

## Timing
- Accept at edge N:
  - Already normalized or zero input: `out_valid` at N+1.
  - Input needing k shifts (1 ≤ k ≤ FRAC_W, `in_exp` ≥ k): `out_valid` at N+k+2.
  - Underflow case: `out_valid` at N+`in_exp`+2.
- Worst-case latency: FRAC_W+2 = 25 cycles.
- All outputs are registered. `in_ready` is decoded from state only, with no combinational path from `out_ready`.
- Throughput: at most one result per latency+1 cycles.

## Structure
- Package `fp_norm_pkg`:
  - FSM state enum (IDLE/SHIFT/DONE).
  - Default constants FRAC_W=23, EXP_W=8, SIG_W=FRAC_W+1.
  - Derived shift-count width.
- No sub-module. A single FSM with a shift register and an exponent decrementer is sufficient.

## Test plan
1. `in_carry`=1, `in_sum`=0x000000, `in_exp`=0x80, `in_sign`=1 -> frac=0x000000, exp=0x80, sign=1, shift=0, `out_valid` one cycle after accept.
2. `in_carry`=0, `in_sum`=0x000001, `in_exp`=0x80 -> frac=0x000000, exp=0x69, shift=23, `out_valid` 25 cycles after accept.
3. `in_carry`=0, `in_sum`=0x000000, `in_exp`=0x55 -> zero=1, exp=0x00, frac=0, underflow=0, `out_valid` one cycle after accept.
4. `in_carry`=0, `in_sum`=0x100000, `in_exp`=0x02 -> underflow=1, exp=0x00, frac=0x400000, shift=2, `out_valid` 4 cycles after accept.
5. Result in DONE with `out_ready`=0 for 5 cycles while `in_valid`=1 -> outputs stable, `in_ready`=0, no second accept. Raise `out_ready` -> IDLE next cycle and the second operand is accepted the cycle after.
6. `rst_n` pulsed low during SHIFT of case 2 -> `out_valid`=0 and all outputs 0 immediately (asynchronously), `in_ready`=1. After release, case 1 is accepted and produces the correct result.
